// File: rtl/ttrng_pkg.sv
// Shared types and default timing constants for the SR-latch TRNG harvest controller.
// TTRNG_HEALTH_EN adds the FAIL state used by the repetition-count health test.
package ttrng_pkg;

   localparam int TTRNG_EXCITE_DEF    = 2;
   localparam int TTRNG_SETTLE_DEF    = 3;
   localparam int TTRNG_REP_LIMIT_DEF = 32;

   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_EXCITE = 3'd1,
      ST_SETTLE = 3'd2,
      ST_SAMPLE = 3'd3,
      ST_HOLD   = 3'd4
`ifdef TTRNG_HEALTH_EN
      ,ST_FAIL  = 3'd5
`endif
   } state_e;

   // The phase counter is loaded with (length - 1), so the larger length sets the width.
   function automatic int cnt_width(int a, int b);
      int m;
      m = (a > b) ? a : b;
      return (m < 2) ? 1 : $clog2(m);
   endfunction

endpackage

// File: rtl/ttrng_harvest_ctrl_if.sv
// Valid/ready byte port carrying harvested random bytes to the consumer.
interface ttrng_harvest_ctrl_if;
   logic [7:0] rnd_data;
   logic       rnd_valid;
   logic       rnd_ready;

   modport master (output rnd_data, output rnd_valid, input rnd_ready);
   modport slave  (input rnd_data, input rnd_valid, output rnd_ready);
endinterface

// File: rtl/ttrng_vn_debias.sv
// Von Neumann corrector: pairs consecutive samples, emits the first bit of a 01/10 pair.
module ttrng_vn_debias (
   input  logic clk,
   input  logic rst,
   input  logic sample_i,
   input  logic bit_i,
   output logic emit_o,
   output logic emit_bit_o
);

   logic have_q;
   logic first_q;

   assign emit_o     = sample_i && have_q && (first_q != bit_i);
   assign emit_bit_o = first_q;

   always_ff @(posedge clk) begin
      if (rst) begin
         have_q  <= 1'b0;
         first_q <= 1'b0;
      end else if (sample_i) begin
         if (have_q) begin
            have_q  <= 1'b0;
            first_q <= 1'b0;
         end else begin
            have_q  <= 1'b1;
            first_q <= bit_i;
         end
      end
   end

endmodule

// File: rtl/ttrng_harvest_ctrl.sv
// Excite/settle/sample sequencer for the SR-latch TRNG with debiasing and byte output.
// Optional build macro TTRNG_HEALTH_EN enables the repetition-count health test.
//
// state  | meaning
// IDLE   | waiting for enable
// EXCITE | latch forced to S=R=1 (latch_force high)
// SETTLE | latch released, waiting for metastability and synchronizer
// SAMPLE | one synchronized sample taken into the corrector
// HOLD   | full byte waiting for the output slot to free
// FAIL   | health test tripped, only rst exits (macro builds only)
module ttrng_harvest_ctrl
   import ttrng_pkg::*;
#(
   parameter int EXCITE_CYCLES = TTRNG_EXCITE_DEF,
   parameter int SETTLE_CYCLES = TTRNG_SETTLE_DEF
`ifdef TTRNG_HEALTH_EN
   ,parameter int REP_LIMIT    = TTRNG_REP_LIMIT_DEF
`endif
) (
   input  logic                        clk,
   input  logic                        rst,
   input  logic                        enable,
   output logic                        latch_force,
   input  logic                        raw_bit,
   output logic                        health_fail,
   ttrng_harvest_ctrl_if.master        rnd
);

   localparam int               CNT_W    = cnt_width(EXCITE_CYCLES, SETTLE_CYCLES);
   localparam logic [CNT_W-1:0] EXC_LOAD = CNT_W'(EXCITE_CYCLES - 1);
   localparam logic [CNT_W-1:0] SET_LOAD = CNT_W'(SETTLE_CYCLES - 1);

   logic             sync1_q, sync2_q;
   state_e           state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [7:0]       shift_q, shift_d;
   logic [3:0]       bitcnt_q, bitcnt_d;
   logic [7:0]       data_q, data_d;
   logic             valid_q, valid_d;
   logic             latch_q;
   logic             sample_stb, vn_emit, vn_bit, slot_free;
   state_e           run_st;

`ifdef TTRNG_HEALTH_EN
   localparam int             REP_W   = $clog2(REP_LIMIT + 1);
   localparam logic [REP_W-1:0] REP_SAT = REP_W'(REP_LIMIT);
   logic [REP_W-1:0] rep_q, rep_d;
   logic             last_q, last_d;
   logic             fail_q, fail_d;
`endif

   assign sample_stb = (state_q == ST_SAMPLE);
   assign slot_free  = !valid_q || rnd.rnd_ready;
   assign run_st     = enable ? ST_EXCITE : ST_IDLE;

   ttrng_vn_debias u_vn (
      .clk        (clk),
      .rst        (rst),
      .sample_i   (sample_stb),
      .bit_i      (sync2_q),
      .emit_o     (vn_emit),
      .emit_bit_o (vn_bit)
   );

   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      shift_d  = shift_q;
      bitcnt_d = bitcnt_q;
      data_d   = data_q;
      valid_d  = valid_q;
`ifdef TTRNG_HEALTH_EN
      rep_d    = rep_q;
      last_d   = last_q;
      fail_d   = fail_q;
`endif
      if (valid_q && rnd.rnd_ready) valid_d = 1'b0;
      if (vn_emit) begin
         shift_d  = {shift_q[6:0], vn_bit};
         bitcnt_d = bitcnt_q + 4'd1;
      end

      case (state_q)
         ST_IDLE:   if (enable) state_d = ST_EXCITE;
         ST_EXCITE: if (cnt_q == '0) state_d = ST_SETTLE; else cnt_d = cnt_q - 1'b1;
         ST_SETTLE: if (cnt_q == '0) state_d = ST_SAMPLE; else cnt_d = cnt_q - 1'b1;
         ST_SAMPLE: begin
            state_d = run_st;
            if (vn_emit && bitcnt_q == 4'd7) begin
               if (slot_free) begin
                  data_d   = shift_d;
                  valid_d  = 1'b1;
                  bitcnt_d = 4'd0;
               end else begin
                  state_d = ST_HOLD;
               end
            end
         end
         ST_HOLD: begin
            if (slot_free) begin
               data_d   = shift_q;
               valid_d  = 1'b1;
               bitcnt_d = 4'd0;
               state_d  = run_st;
            end
         end
         default: valid_d = 1'b0;
      endcase

`ifdef TTRNG_HEALTH_EN
      // Run length counts the current sample, so a fresh value restarts at 1.
      if (sample_stb) begin
         last_d = sync2_q;
         if (rep_q != '0 && sync2_q == last_q) begin
            if (rep_q != REP_SAT) rep_d = rep_q + 1'b1;
         end else begin
            rep_d = REP_W'(1);
         end
         if (rep_d == REP_SAT) begin
            fail_d   = 1'b1;
            state_d  = ST_FAIL;
            valid_d  = 1'b0;
            bitcnt_d = 4'd0;
         end
      end
`endif

      if (state_d != state_q) begin
         case (state_d)
            ST_EXCITE: cnt_d = EXC_LOAD;
            ST_SETTLE: cnt_d = SET_LOAD;
            default:   cnt_d = '0;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         sync1_q  <= 1'b0;
         sync2_q  <= 1'b0;
         state_q  <= ST_IDLE;
         cnt_q    <= '0;
         shift_q  <= '0;
         bitcnt_q <= '0;
         data_q   <= '0;
         valid_q  <= 1'b0;
         latch_q  <= 1'b0;
`ifdef TTRNG_HEALTH_EN
         rep_q    <= '0;
         last_q   <= 1'b0;
         fail_q   <= 1'b0;
`endif
      end else begin
         sync1_q  <= raw_bit;
         sync2_q  <= sync1_q;
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         shift_q  <= shift_d;
         bitcnt_q <= bitcnt_d;
         data_q   <= data_d;
         valid_q  <= valid_d;
         latch_q  <= (state_d == ST_EXCITE);
`ifdef TTRNG_HEALTH_EN
         rep_q    <= rep_d;
         last_q   <= last_d;
         fail_q   <= fail_d;
`endif
      end
   end

   assign latch_force   = latch_q;
   assign rnd.rnd_data  = data_q;
   assign rnd.rnd_valid = valid_q;
`ifdef TTRNG_HEALTH_EN
   assign health_fail   = fail_q;
`else
   assign health_fail   = 1'b0;
`endif

endmodule
